// File: rtl/ddr_package.sv
// Shared types for the ACT/PRE command scheduler: address type, rw codes,
// scheduler states and the delay-counter load helper.
package ddr_package;

    typedef logic [31:0] mem_addr_type;

    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = 255;

    // state       | meaning
    // ST_IDLE     | waiting for a request or refresh
    // ST_ACT      | act_rdy strobe, both counters loaded
    // ST_WAIT_RCD | ACT-to-CAS spacing
    // ST_CAS      | cas_rdy strobe, post-CAS recovery loaded
    // ST_WAIT_PRE | waiting for tRAS and read/write recovery
    // ST_PRE      | pre_rdy strobe
    // ST_WAIT_RP  | precharge recovery
    // ST_REF      | refresh_rdy strobe
    // ST_WAIT_RFC | refresh busy time
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ACT,
        ST_WAIT_RCD,
        ST_CAS,
        ST_WAIT_PRE,
        ST_PRE,
        ST_WAIT_RP,
        ST_REF,
        ST_WAIT_RFC
    } sched_state_t;

    // A wait state leaves on the cycle its counter reads zero, so a spacing of
    // D cycles between the loading strobe and the next state needs a load of D-2.
    function automatic logic [CNT_W-1:0] delay_load(input int cycles);
        if (cycles <= 2) begin
            return '0;
        end else if (cycles - 2 >= CNT_MAX) begin
            return 8'hFF;
        end else begin
            return CNT_W'(cycles - 2);
        end
    endfunction

endpackage

// File: rtl/sched_delay_counter.sv
// 8-bit unsigned down-counter with synchronous load; zero flags terminal count
// and holds there until the next load.
module sched_delay_counter
    import ddr_package::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             count_en,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count_en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/act_pre_scheduler.sv
// Single-bank ACT/CAS/PRE/REF sequencer: accepts one request at a time and
// spaces the command strobes by the DRAM timing parameters.
module act_pre_scheduler
    import ddr_package::*;
#(
    parameter int tRCD = 4,
    parameter int tRAS = 10,
    parameter int tRP  = 4,
    parameter int tRTP = 2,
    parameter int tWR  = 4,
    parameter int tRFC = 20
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         config_done,
    input  int           CWL,
    input  int           BL,
    input  logic         req_valid,
    output logic         req_ready,
    input  mem_addr_type req_addr,
    input  logic [1:0]   req_rw,
    input  logic         ref_req,
    output logic         act_rdy,
    output logic         cas_rdy,
    output logic         pre_rdy,
    output logic         refresh_rdy,
    output mem_addr_type cmd_addr,
    output logic [1:0]   cas_rw,
    output logic         rw_idle,
    output logic         req_err
);

    // Every wait state lasts at least one cycle, so spacings below 2 cannot be met.
    if (tRCD < 2 || tRCD > CNT_MAX || tRAS < 1 || tRAS > CNT_MAX ||
        tRP < 2 || tRP > CNT_MAX || tRTP < 2 || tRTP > CNT_MAX ||
        tWR < 1 || tWR > CNT_MAX || tRFC < 1 || tRFC > CNT_MAX) begin : g_param_check
        $error("act_pre_scheduler: timing parameter outside 8-bit counter range");
    end

    sched_state_t     state, next_state;
    logic             accept, rw_legal;
    logic             act_load, main_load;
    logic [CNT_W-1:0] main_value;
    logic             act_zero, main_zero;
    int               write_post;

    assign rw_legal   = (req_rw == RW_READ) || (req_rw == RW_WRITE);
    // Gated by reset_n so the handshake reads 0 for as long as reset is held.
    assign req_ready  = reset_n & (state == ST_IDLE) & config_done & ~ref_req;
    assign accept     = req_valid & req_ready;
    assign req_err    = accept & ~rw_legal;
    assign write_post = CWL + BL / 2 + tWR;

    assign act_rdy     = (state == ST_ACT);
    assign cas_rdy     = (state == ST_CAS);
    assign pre_rdy     = (state == ST_PRE);
    assign refresh_rdy = (state == ST_REF);
    assign rw_idle     = (state == ST_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_addr <= '0;
            cas_rw   <= 2'b00;
        end else if (accept && rw_legal) begin
            cmd_addr <= req_addr;
            cas_rw   <= req_rw;
        end
    end

    always_comb begin
        next_state = state;
        act_load   = 1'b0;
        main_load  = 1'b0;
        main_value = '0;
        unique case (state)
            ST_IDLE: begin
                if (config_done && ref_req) begin
                    next_state = ST_REF;
                end else if (accept && rw_legal) begin
                    next_state = ST_ACT;
                end
            end
            ST_ACT: begin
                act_load   = 1'b1;
                main_load  = 1'b1;
                main_value = delay_load(tRCD);
                next_state = ST_WAIT_RCD;
            end
            ST_WAIT_RCD: begin
                if (main_zero) begin
                    next_state = ST_CAS;
                end
            end
            ST_CAS: begin
                main_load  = 1'b1;
                main_value = (cas_rw == RW_WRITE) ? delay_load(write_post) : delay_load(tRTP);
                next_state = ST_WAIT_PRE;
            end
            ST_WAIT_PRE: begin
                if (act_zero && main_zero) begin
                    next_state = ST_PRE;
                end
            end
            ST_PRE: begin
                main_load  = 1'b1;
                main_value = delay_load(tRP);
                next_state = ST_WAIT_RP;
            end
            ST_WAIT_RP: begin
                if (main_zero) begin
                    next_state = ST_IDLE;
                end
            end
            ST_REF: begin
                // WAIT_RFC itself spans tRFC cycles, one more than a strobe-to-strobe gap.
                main_load  = 1'b1;
                main_value = delay_load(tRFC + 1);
                next_state = ST_WAIT_RFC;
            end
            ST_WAIT_RFC: begin
                if (main_zero) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    sched_delay_counter u_act_delay (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (act_load),
        .count_en   (1'b1),
        .load_value (delay_load(tRAS)),
        .zero       (act_zero)
    );

    sched_delay_counter u_main_delay (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (main_load),
        .count_en   (1'b1),
        .load_value (main_value),
        .zero       (main_zero)
    );

endmodule

// File: tb/tb_act_pre_scheduler.sv
// Scoreboard bench for act_pre_scheduler: stimulus queues expected strobes with
// their cycle numbers, a negedge monitor pops and compares them.
module tb_act_pre_scheduler;
    import ddr_package::*;

    localparam int K_ACT = 0;
    localparam int K_CAS = 1;
    localparam int K_PRE = 2;
    localparam int K_REF = 3;

    typedef struct {
        int           kind;
        int           cyc;
        logic [1:0]   rw;
        mem_addr_type addr;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         config_done = 1'b1;
    int           cwl = 5;
    int           bl = 8;
    logic         req_valid = 1'b0;
    logic         req_ready;
    mem_addr_type req_addr = '0;
    logic [1:0]   req_rw = 2'b00;
    logic         ref_req = 1'b0;
    logic         act_rdy, cas_rdy, pre_rdy, refresh_rdy;
    mem_addr_type cmd_addr;
    logic [1:0]   cas_rw;
    logic         rw_idle, req_err;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   mon_kind;

    act_pre_scheduler #(
        .tRCD(4), .tRAS(10), .tRP(4), .tRTP(2), .tWR(4), .tRFC(20)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .config_done (config_done),
        .CWL         (cwl),
        .BL          (bl),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_rw      (req_rw),
        .ref_req     (ref_req),
        .act_rdy     (act_rdy),
        .cas_rdy     (cas_rdy),
        .pre_rdy     (pre_rdy),
        .refresh_rdy (refresh_rdy),
        .cmd_addr    (cmd_addr),
        .cas_rw      (cas_rw),
        .rw_idle     (rw_idle),
        .req_err     (req_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input logic [1:0] rw, input mem_addr_type addr);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.rw   = rw;
        e.addr = addr;
        exp_q.push_back(e);
    endtask

    // ACT one cycle after acceptance, CAS tRCD later, PRE at pre_off.
    task automatic push_seq(input int acc, input int pre_off, input logic [1:0] rw, input mem_addr_type addr);
        push(K_ACT, acc + 1, rw, addr);
        push(K_CAS, acc + 5, rw, addr);
        push(K_PRE, acc + pre_off, rw, addr);
    endtask

    // Called #1 after a posedge; returns #1 after the accepting posedge.
    task automatic offer(input logic [1:0] rw, input mem_addr_type addr, output int acc);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        acc       = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (req_ready) begin
                acc = cyc;
                break;
            end
        end
        check("accept_within_bound", longint'(acc >= 0), 1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (rw_idle) begin
                ok = 1'b1;
                break;
            end
        end
        check("reached_idle", longint'(ok), 1);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) begin
            @(posedge clock);
            #1;
        end
    endtask

    always @(negedge clock) begin
        if (act_rdy || cas_rdy || pre_rdy || refresh_rdy) begin
            check("strobe_one_hot", $countones({act_rdy, cas_rdy, pre_rdy, refresh_rdy}), 1);
            mon_kind = act_rdy ? K_ACT : cas_rdy ? K_CAS : pre_rdy ? K_PRE : K_REF;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: kind %0d at cycle %0d, none expected", mon_kind, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_kind", mon_kind, mon_e.kind);
                check("strobe_cycle", cyc, mon_e.cyc);
                if (mon_kind == K_CAS) begin
                    check("cas_rw", longint'(cas_rw), longint'(mon_e.rw));
                    check("cmd_addr_at_cas", longint'(cmd_addr), longint'(mon_e.addr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, w, c, r, acc, first, ready_seen;

        // reset values while reset_n held low
        #3;
        check("rst_rw_idle", longint'(rw_idle), 1);
        check("rst_req_ready", longint'(req_ready), 0);
        check("rst_req_err", longint'(req_err), 0);
        check("rst_strobes", longint'({act_rdy, cas_rdy, pre_rdy, refresh_rdy}), 0);
        check("rst_cmd_addr", longint'(cmd_addr), 0);
        check("rst_cas_rw", longint'(cas_rw), 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // back-to-back reads: second ACT no earlier than PRE + tRP
        offer(RW_READ, 32'h0000_1234, a);
        push_seq(a, 11, RW_READ, 32'h0000_1234);
        offer(RW_READ, 32'h00AB_CDEF, b);
        push_seq(b, 11, RW_READ, 32'h00AB_CDEF);
        check("read_next_accept", b, a + 15);

        // config_done falling mid-sequence must not abort it
        wait_cycle(b + 2);
        config_done = 1'b0;
        wait_idle();
        config_done = 1'b1;

        // write: PRE at CAS + CWL + BL/2 + tWR, req_ready back 22 after acceptance
        offer(RW_WRITE, 32'hDEAD_BEEF, w);
        push_seq(w, 18, RW_WRITE, 32'hDEAD_BEEF);
        first = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (req_ready) begin
                first = cyc;
                break;
            end
        end
        check("write_ready_return", first, w + 22);
        @(posedge clock);
        #1;

        // refresh and request together: REF first, request waits out tRFC
        c = cyc;
        ref_req   = 1'b1;
        req_valid = 1'b1;
        req_rw    = RW_READ;
        req_addr  = 32'h0000_5555;
        push(K_REF, c + 1, 2'b00, '0);
        @(posedge clock);
        #1;
        ref_req = 1'b0;
        offer(RW_READ, 32'h0000_5555, acc);
        push_seq(acc, 11, RW_READ, 32'h0000_5555);
        check("ref_then_accept", acc, c + 22);
        wait_idle();

        // refresh raised while busy is held until WAIT_RP completes
        offer(RW_READ, 32'h0F0F_0F0F, r);
        push_seq(r, 11, RW_READ, 32'h0F0F_0F0F);
        wait_cycle(r + 3);
        ref_req = 1'b1;
        push(K_REF, r + 16, 2'b00, '0);
        wait_cycle(r + 16);
        ref_req = 1'b0;
        wait_idle();

        // illegal rw: req_err pulse only, no command
        req_valid = 1'b1;
        req_rw    = 2'b11;
        req_addr  = 32'h1111_1111;
        @(negedge clock);
        check("illegal_ready", longint'(req_ready), 1);
        check("illegal_req_err", longint'(req_err), 1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        check("illegal_err_cleared", longint'(req_err), 0);
        check("illegal_rw_idle", longint'(rw_idle), 1);
        repeat (3) @(posedge clock);
        #1;

        // config_done low blocks acceptance for 50 cycles
        config_done = 1'b0;
        req_valid   = 1'b1;
        req_rw      = RW_READ;
        ready_seen  = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (req_ready) ready_seen++;
        end
        check("cfg_low_no_ready", ready_seen, 0);
        @(posedge clock);
        #1;
        config_done = 1'b1;
        offer(RW_READ, 32'h0000_0077, acc);
        push_seq(acc, 11, RW_READ, 32'h0000_0077);
        wait_idle();

        // reset between ACT and CAS discards the request
        offer(RW_WRITE, 32'hCAFE_F00D, r);
        push(K_ACT, r + 1, RW_WRITE, 32'hCAFE_F00D);
        wait_cycle(r + 3);
        check("latched_addr", longint'(cmd_addr), longint'(32'hCAFE_F00D));
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_rw_idle", longint'(rw_idle), 1);
        check("midrst_strobes", longint'({act_rdy, cas_rdy, pre_rdy, refresh_rdy}), 0);
        check("midrst_cmd_addr", longint'(cmd_addr), 0);
        check("midrst_cas_rw", longint'(cas_rw), 0);
        check("midrst_req_ready", longint'(req_ready), 0);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        offer(RW_READ, 32'h0000_00A5, acc);
        push_seq(acc, 11, RW_READ, 32'h0000_00A5);
        wait_idle();

        repeat (5) @(posedge clock);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
